// File: rtl/sequenciador_acumulador.sv
// Block-sum sequencer: reads Count words from BaseAddr and drives Clear/Load/Transfer into the
// accumulator. Define SEQ_OVERFLOW_EN to add the sticky carry-out Overflow output.
module sequenciador_acumulador #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 16
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Start,
    input  logic [ADDR_W-1:0] BaseAddr,
    input  logic [ADDR_W:0]   Count,
    output logic [ADDR_W-1:0] MemAddr,
    output logic              MemRd,
    input  logic [DATA_W-1:0] MemData,
    output logic [DATA_W-1:0] DataToAcc,
    output logic              Clear,
    output logic              Load,
    output logic              Transfer,
    output logic              Busy,
`ifdef SEQ_OVERFLOW_EN
    output logic              Done,
    output logic              Overflow
`else
    output logic              Done
`endif
);

    typedef enum logic [2:0] {
        StIdle,
        StClr,
        StFetch,
        StWait,
        StLd,
        StXfr,
        StFin
    } state_e;

    localparam logic [ADDR_W:0] CntOne = 1;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   remaining_q, remaining_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              mem_rd_q, clear_q, load_q, transfer_q, busy_q, done_q;

`ifdef SEQ_OVERFLOW_EN
    logic [DATA_W:0]   shadow_q, shadow_d;
    logic              overflow_q, overflow_d;
`endif

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        data_d      = data_q;
        case (state_q)
            StIdle: begin
                if (Start) begin
                    addr_d      = BaseAddr;
                    remaining_d = Count;
                    state_d     = StClr;
                end
            end
            StClr:   state_d = (remaining_q == '0) ? StFin : StFetch;
            StFetch: state_d = StWait;
            StWait: begin
                data_d  = MemData;
                state_d = StLd;
            end
            StLd:    state_d = StXfr;
            StXfr: begin
                addr_d      = addr_q + 1'b1;
                remaining_d = remaining_q - CntOne;
                state_d     = (remaining_q == CntOne) ? StFin : StFetch;
            end
            StFin:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
        // Address is latched on entry to FETCH so it holds the last issued word once idle.
        mem_addr_d = (state_d == StFetch) ? addr_d : mem_addr_q;
    end

`ifdef SEQ_OVERFLOW_EN
    always_comb begin
        shadow_d   = shadow_q;
        overflow_d = overflow_q;
        if (state_d == StClr) begin
            shadow_d   = '0;
            overflow_d = 1'b0;
        end else if (state_q == StXfr) begin
            shadow_d   = {1'b0, shadow_q[DATA_W-1:0]} + {1'b0, data_q};
            overflow_d = overflow_q | shadow_d[DATA_W];
        end
    end
`endif

    // Strobes are registered decodes of the next state, so each output comes straight from a flop.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            remaining_q <= '0;
            mem_addr_q  <= '0;
            data_q      <= '0;
            mem_rd_q    <= 1'b0;
            clear_q     <= 1'b0;
            load_q      <= 1'b0;
            transfer_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            mem_addr_q  <= mem_addr_d;
            data_q      <= data_d;
            mem_rd_q    <= (state_d == StFetch);
            clear_q     <= (state_d == StClr);
            load_q      <= (state_d == StLd);
            transfer_q  <= (state_d == StXfr);
            busy_q      <= (state_d != StIdle);
            done_q      <= (state_d == StFin);
        end
    end

`ifdef SEQ_OVERFLOW_EN
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            shadow_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            shadow_q   <= shadow_d;
            overflow_q <= overflow_d;
        end
    end

    assign Overflow = overflow_q;
`endif

    assign MemAddr   = mem_addr_q;
    assign MemRd     = mem_rd_q;
    assign DataToAcc = data_q;
    assign Clear     = clear_q;
    assign Load      = load_q;
    assign Transfer  = transfer_q;
    assign Busy      = busy_q;
    assign Done      = done_q;

endmodule

// File: tb/tb_sequenciador_acumulador.sv
// Directed bench for sequenciador_acumulador with a synchronous memory and accumulator model.
// Overflow checks are compiled in when SEQ_OVERFLOW_EN is defined.
module tb_sequenciador_acumulador;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  base_addr = '0;
    logic [8:0]  count = '0;
    logic [7:0]  mem_addr;
    logic        mem_rd;
    logic [15:0] mem_data = '0;
    logic [15:0] data_to_acc;
    logic        clear, load, transfer, busy, done;
`ifdef SEQ_OVERFLOW_EN
    logic        overflow;
`endif

    logic [15:0] mem [256];
    logic [15:0] acc = '0;
    logic [15:0] acc_b = '0;

    int n_checks = 0;
    int n_errors = 0;
    int n_clr = 0, n_ld = 0, n_xfr = 0, n_rd = 0, n_busy = 0, n_done = 0;
    logic [7:0] rd_addrs [$];

    sequenciador_acumulador dut (
        .Clock     (clk),
        .Reset     (rst),
        .Start     (start),
        .BaseAddr  (base_addr),
        .Count     (count),
        .MemAddr   (mem_addr),
        .MemRd     (mem_rd),
        .MemData   (mem_data),
        .DataToAcc (data_to_acc),
        .Clear     (clear),
        .Load      (load),
        .Transfer  (transfer),
        .Busy      (busy),
`ifdef SEQ_OVERFLOW_EN
        .Done      (done),
        .Overflow  (overflow)
`else
        .Done      (done)
`endif
    );

    always #5 clk = ~clk;

    // Synchronous-read memory and the downstream accumulator.
    always @(posedge clk) begin
        if (mem_rd) mem_data <= mem[mem_addr];
        if (clear) acc <= '0;
        if (load) acc_b <= data_to_acc;
        if (transfer) acc <= acc + acc_b;
    end

    always @(negedge clk) begin
        if (clear) n_clr++;
        if (load) n_ld++;
        if (transfer) n_xfr++;
        if (busy) n_busy++;
        if (done) n_done++;
        if (mem_rd) begin
            n_rd++;
            rd_addrs.push_back(mem_addr);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Pulses Start for one cycle and returns the cycle index of Done (-1 on timeout).
    task automatic run(input logic [7:0] base, input logic [8:0] cnt, output int cyc);
        @(negedge clk);
        base_addr = base;
        count = cnt;
        start = 1'b1;
        n_clr = 0; n_ld = 0; n_xfr = 0; n_rd = 0; n_busy = 0; n_done = 0;
        rd_addrs.delete();
        @(negedge clk);
        start = 1'b0;
        cyc = -1;
        for (int k = 1; k <= 2000; k++) begin
            if (done) begin
                cyc = k;
                break;
            end
            @(negedge clk);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset;
        logic [29:0] outs;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        outs = {mem_addr, mem_rd, data_to_acc, clear, load, transfer, busy, done};
        n_checks++;
        if (outs !== '0) begin
            n_errors++;
            $display("FAIL reset_outputs: got %h expected 0", outs);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        outs = {mem_addr, mem_rd, data_to_acc, clear, load, transfer, busy, done};
        n_checks++;
        if (outs !== '0) begin
            n_errors++;
            $display("FAIL idle_after_reset: got %h expected 0", outs);
        end
    endtask

    task automatic test_basic;
        int cyc;
        mem[8'h10] = 16'd1; mem[8'h11] = 16'd2; mem[8'h12] = 16'd3; mem[8'h13] = 16'd4;
        run(8'h10, 9'd4, cyc);
        n_checks++;
        if (cyc !== 18) begin n_errors++; $display("FAIL basic_latency: got %0d expected 18", cyc); end
        n_checks++;
        if (acc !== 16'd10) begin n_errors++; $display("FAIL basic_sum: got %0d expected 10", acc); end
        n_checks++;
        if (n_clr !== 1) begin n_errors++; $display("FAIL basic_clears: got %0d expected 1", n_clr); end
        n_checks++;
        if (n_ld !== 4 || n_xfr !== 4 || n_rd !== 4) begin
            n_errors++;
            $display("FAIL basic_strobes: ld=%0d xfr=%0d rd=%0d expected 4 each", n_ld, n_xfr, n_rd);
        end
        n_checks++;
        if (n_busy !== 18) begin n_errors++; $display("FAIL basic_busy: got %0d expected 18", n_busy); end
        n_checks++;
        if (n_done !== 1) begin n_errors++; $display("FAIL basic_done: got %0d expected 1", n_done); end
        n_checks++;
        if (mem_addr !== 8'h13 || data_to_acc !== 16'd4) begin
            n_errors++;
            $display("FAIL basic_hold: addr=%h data=%h expected 13/0004", mem_addr, data_to_acc);
        end
    endtask

    task automatic test_zero_count;
        int cyc;
        run(8'h10, 9'd0, cyc);
        n_checks++;
        if (cyc !== 2) begin n_errors++; $display("FAIL zero_latency: got %0d expected 2", cyc); end
        n_checks++;
        if (n_clr !== 1 || n_rd !== 0 || n_ld !== 0 || n_xfr !== 0) begin
            n_errors++;
            $display("FAIL zero_strobes: clr=%0d rd=%0d ld=%0d xfr=%0d expected 1/0/0/0",
                     n_clr, n_rd, n_ld, n_xfr);
        end
        n_checks++;
        if (acc !== 16'd0) begin n_errors++; $display("FAIL zero_sum: got %0d expected 0", acc); end
    endtask

    task automatic test_wrap;
        int cyc;
        logic [23:0] seq;
        mem[8'hFF] = 16'd5; mem[8'h00] = 16'd6; mem[8'h01] = 16'd7;
        run(8'hFF, 9'd3, cyc);
        seq = (rd_addrs.size() == 3) ? {rd_addrs[0], rd_addrs[1], rd_addrs[2]} : 24'hxxxxxx;
        n_checks++;
        if (seq !== 24'hFF0001) begin
            n_errors++;
            $display("FAIL wrap_addrs: got %h expected ff0001", seq);
        end
        n_checks++;
        if (acc !== 16'd18) begin n_errors++; $display("FAIL wrap_sum: got %0d expected 18", acc); end
        n_checks++;
        if (cyc !== 14) begin n_errors++; $display("FAIL wrap_latency: got %0d expected 14", cyc); end
    endtask

    task automatic test_busy_restart;
        int dones, t1, t2;
        mem[8'h20] = 16'd1; mem[8'h21] = 16'd1;
        @(negedge clk);
        base_addr = 8'h20; count = 9'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        dones = 0;
        repeat (30) begin
            if (done) dones++;
            @(negedge clk);
        end
        n_checks++;
        if (dones !== 1) begin n_errors++; $display("FAIL restart_ignored: got %0d dones expected 1", dones); end
        n_checks++;
        if (acc !== 16'd2) begin n_errors++; $display("FAIL restart_sum: got %0d expected 2", acc); end

        count = 9'd1;
        start = 1'b1;
        t1 = -1; t2 = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (done) begin
                if (t1 < 0) t1 = k;
                else begin
                    t2 = k;
                    start = 1'b0;
                    break;
                end
            end
        end
        start = 1'b0;
        n_checks++;
        if (t1 !== 6) begin n_errors++; $display("FAIL held_first_done: got %0d expected 6", t1); end
        n_checks++;
        if (t2 - t1 !== 7) begin n_errors++; $display("FAIL held_done_gap: got %0d expected 7", t2 - t1); end
        repeat (12) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin n_errors++; $display("FAIL held_stop: busy=%b expected 0", busy); end
    endtask

    task automatic test_mid_reset;
        int lc, cyc;
        logic [29:0] outs;
        mem[8'h40] = 16'd10; mem[8'h41] = 16'd20; mem[8'h42] = 16'd30; mem[8'h43] = 16'd40;
        @(negedge clk);
        base_addr = 8'h40; count = 9'd4; start = 1'b1;
        n_clr = 0; n_ld = 0; n_xfr = 0; n_rd = 0; n_busy = 0; n_done = 0;
        @(negedge clk);
        start = 1'b0;
        lc = 0;
        for (int k = 0; k < 40; k++) begin
            if (load) lc++;
            if (lc == 2) break;
            @(negedge clk);
        end
        rst = 1'b1;
        #1;
        outs = {mem_addr, mem_rd, data_to_acc, clear, load, transfer, busy, done};
        n_checks++;
        if (lc !== 2 || outs !== '0) begin
            n_errors++;
            $display("FAIL midreset_outputs: loads=%0d outs=%h expected 2/0", lc, outs);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        n_checks++;
        if (n_xfr !== 1 || n_ld !== 2 || n_done !== 0) begin
            n_errors++;
            $display("FAIL midreset_abort: xfr=%0d ld=%0d done=%0d expected 1/2/0", n_xfr, n_ld, n_done);
        end
        run(8'h40, 9'd4, cyc);
        n_checks++;
        if (acc !== 16'd100 || cyc !== 18) begin
            n_errors++;
            $display("FAIL midreset_rerun: sum=%0d cyc=%0d expected 100/18", acc, cyc);
        end
    endtask

`ifdef SEQ_OVERFLOW_EN
    task automatic test_overflow;
        int cyc;
        mem[8'h80] = 16'hFFFF; mem[8'h81] = 16'h0002;
        mem[8'h82] = 16'h0001; mem[8'h83] = 16'h0002;
        run(8'h80, 9'd2, cyc);
        n_checks++;
        if (acc !== 16'h0001 || overflow !== 1'b1) begin
            n_errors++;
            $display("FAIL overflow_set: sum=%h ovf=%b expected 0001/1", acc, overflow);
        end
        run(8'h82, 9'd2, cyc);
        n_checks++;
        if (acc !== 16'h0003 || overflow !== 1'b0) begin
            n_errors++;
            $display("FAIL overflow_clear: sum=%h ovf=%b expected 0003/0", acc, overflow);
        end
    endtask
`endif

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        test_reset();
        test_basic();
        test_zero_count();
        test_wrap();
        test_busy_restart();
        test_mid_reset();
`ifdef SEQ_OVERFLOW_EN
        test_overflow();
`endif
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
